enb_arbiter: RTL and testbench
==============================

# enb_arbiter

Controller that shares the gated-clock resource among `N` requesters. It grants a burst of exactly `BURST` gated clock pulses to one requester at a time, then enforces an idle gap before the next grant. Each `enb[i]` output drives the `enb` input of one clock-enabler instance. Each enable is retimed on the falling edge of `clk`, so it is stable for the whole high phase of `clk` and the gated clock never glitches.

## Interface
- `N`, 4: number of requesters, 2..8.
- `BURST`, 8: gated pulses per grant, 1..255.
- `GAP`, 1: idle cycles between grants, 1..15.
- `clk`  in  1  system clock; also the clock that the enablers gate.
- `reset_L`  in  1  asynchronous, active-low reset.
- `req`  in  N  request per requester; level-sensitive, sampled on rising `clk`.
- `enb`  out  N  one-hot-or-zero enable to each enabler; updated on falling `clk`.
- `grant_id`  out  $clog2(N)  index of the current or last winner; rising-edge register.
- `busy`  out  1  high in GRANT and GAP; rising-edge register.
- `done`  out  1  one-cycle pulse when a burst completes on count expiry; rising-edge register.

## Operation
- States: IDLE, GRANT, GAP. Reset values:
  - state = IDLE, `enb` = 0, `grant_id` = 0, `busy` = 0, `done` = 0.
  - internal grant vector = 0, burst counter = 0, gap counter = 0.
  - round-robin pointer = N-1, so `req[0]` wins first.
- IDLE, with any `req` set:
  - Pick the winner: the first set bit searching upward from pointer+1, wrapping modulo N.
  - Set the grant bit, load counter = BURST-1, update `grant_id` and the pointer to the winner, set `busy`, go to GRANT.
- IDLE with no `req`: stay in IDLE.
- GRANT, each rising edge:
  - Sampled `req[winner]` = 0 → early release: clear the grant, load gap counter = GAP-1, go to GAP. No `done` pulse.
  - Else counter = 0 → clear the grant, pulse `done`, go to GAP.
  - Else decrement the counter.
  - Early release takes priority over expiry when both hold.
- GAP: decrement the gap counter each cycle. At 0, clear `busy` and go to IDLE. Arbitration resumes on the following rising edge.
- A requester that keeps `req` high after its burst is served again only after all other active requesters.
- Requests arriving during GRANT or GAP are not latched. A requester must hold `req` until it is served.
- `enb` is the grant vector captured on falling `clk`. At most one bit is set at any time.

## Timing
- Request latency: with `req` sampled high in IDLE at rising edge k:
  - state = GRANT and grant bit set at edge k.
  - `enb` rises at the falling edge after k.
  - First gated pulse at rising edge k+1.
- Burst without release: gated pulses at rising edges k+1 .. k+BURST, exactly BURST pulses.
  - At rising edge k+BURST: grant cleared and `done` = 1 for that cycle.
  - `enb` falls at the falling edge after k+BURST.
- Early release sampled at edge m: the pulse at edge m still occurs; no pulse after m.
- Minimum spacing between the last pulse of one burst and the first pulse of the next: GAP+2 rising edges.
- Reset is asynchronous: asserting `reset_L` low mid-burst forces `enb` = 0 immediately, with no wait for a clock edge. The current burst is truncated.
- Deassertion of `reset_L` must be synchronous to rising `clk`. The first arbitration happens on the first rising edge after release.

## Configuration
- `ENB_FIXED_PRIORITY_EN` defined:
  - Winner is the lowest set index; the pointer is unused and held at reset value.
  - `req[0]` can starve the others.
- Not defined: round-robin as described in Operation (default).

## Structure
- Shared package `enb_pkg`:
  - State enum (IDLE=2'd0, GRANT=2'd1, GAP=2'd2).
  - Counter widths: BURST counter 8 bits, GAP counter 4 bits.
  - Function `rr_pick(req, ptr)` returning the winner index and a valid flag.
- One sub-module `enb_retime`: N-bit negative-edge register with async active-low clear, producing `enb` from the grant vector.
- FSM, counters and pointer stay in the top-level module.

## Test plan
- Reset, then `req` = 4'b0100 held: `enb[2]` rises after the first falling edge; exactly 8 gated pulses; `done` pulses once; `grant_id` = 2; `busy` drops 1 cycle after GAP.
- `req` = 4'b1111 held, round-robin: grant order 0,1,2,3,0; every burst has 8 pulses; never more than one `enb` bit high.
- Same stimulus with `ENB_FIXED_PRIORITY_EN` defined: `grant_id` stays 0 for 3 consecutive bursts.
- `req` = 4'b0010, dropped after 3 gated pulses: grant ends, 3 pulses seen, `done` stays 0, next grant possible after GAP.
- `reset_L` driven low while clk is high, during pulse 5 of a burst: `enb` = 0 within the same phase; no further gated pulses; state IDLE; pointer = N-1.
- `BURST` = 1, `GAP` = 1, `req` = 4'b0011: alternating single-pulse grants 0,1,0,1; consecutive gated pulses separated by 3 rising edges.

Source files
------------

// File: rtl/enb_pkg.sv
// Shared types, counter widths and the round-robin picker for enb_arbiter.
package enb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam int MAX_N   = 8;
    localparam int IDX_W   = 3;
    localparam int BURST_W = 8;
    localparam int GAP_W   = 4;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // First set request searching upward from ptr+1, wrapping modulo n.
    function automatic pick_t rr_pick(input logic [MAX_N-1:0] req,
                                      input logic [IDX_W-1:0] ptr,
                                      input int               n);
        pick_t            r;
        logic [IDX_W-1:0] cand;
        r = '0;
        for (int k = 1; k <= MAX_N; k++) begin
            cand = IDX_W'((int'(ptr) + k) % n);
            if (k <= n && !r.valid && req[cand]) begin
                r.valid = 1'b1;
                r.idx   = cand;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/enb_retime.sv
// Falling-edge register turning the grant vector into the enabler inputs.
module enb_retime #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset_L,
    input  logic [N-1:0] grant,
    output logic [N-1:0] enb
);

    // Capturing on the falling edge keeps enb stable for the whole high phase.
    always_ff @(negedge clk or negedge reset_L) begin
        if (!reset_L) enb <= '0;
        else          enb <= grant;
    end

endmodule

// File: rtl/enb_arbiter.sv
// Burst arbiter for the gated-clock resource: IDLE -> GRANT -> GAP.
// Define ENB_FIXED_PRIORITY_EN for lowest-index-wins instead of round-robin.
module enb_arbiter
    import enb_pkg::*;
#(
    parameter int N     = 4,
    parameter int BURST = 8,
    parameter int GAP   = 1
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         enb,
    output logic [$clog2(N)-1:0] grant_id,
    output logic                 busy,
    output logic                 done
);

    localparam int ID_W = $clog2(N);

    state_t             state, state_next;
    logic [N-1:0]       grant, grant_next;
    logic [BURST_W-1:0] burst_cnt, burst_next;
    logic [GAP_W-1:0]   gap_cnt, gap_next;
    logic [ID_W-1:0]    ptr, ptr_next, id_next;
    logic               busy_next, done_next;
    logic [MAX_N-1:0]   req_ext;
    logic [IDX_W-1:0]   ptr_ext;
    logic               released;
    pick_t              pick;

    always_comb begin
        req_ext        = '0;
        req_ext[N-1:0] = req;
    end

`ifdef ENB_FIXED_PRIORITY_EN
    // Searching from N-1 wraps straight to index 0, so the lowest request wins.
    assign ptr_ext = IDX_W'(N - 1);
`else
    assign ptr_ext = IDX_W'(ptr);
`endif

    assign pick     = rr_pick(req_ext, ptr_ext, N);
    assign released = (req & grant) == '0;

    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_next = state;
        grant_next = grant;
        burst_next = burst_cnt;
        gap_next   = gap_cnt;
        ptr_next   = ptr;
        id_next    = grant_id;
        busy_next  = busy;
        done_next  = 1'b0;
        unique case (state)
            IDLE: begin
                if (pick.valid) begin
                    grant_next = N'(1) << pick.idx;
                    burst_next = BURST_W'(BURST - 1);
                    id_next    = pick.idx[ID_W-1:0];
`ifndef ENB_FIXED_PRIORITY_EN
                    ptr_next   = pick.idx[ID_W-1:0];
`endif
                    busy_next  = 1'b1;
                    state_next = GRANT;
                end
            end
            GRANT: begin
                // An early release wins over expiry and never pulses done.
                if (released || burst_cnt == '0) begin
                    done_next  = !released;
                    grant_next = '0;
                    gap_next   = GAP_W'(GAP - 1);
                    state_next = enb_pkg::GAP;
                end else begin
                    burst_next = burst_cnt - 1'b1;
                end
            end
            enb_pkg::GAP: begin
                if (gap_cnt == '0) begin
                    busy_next  = 1'b0;
                    state_next = IDLE;
                end else begin
                    gap_next = gap_cnt - 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state     <= IDLE;
            grant     <= '0;
            burst_cnt <= '0;
            gap_cnt   <= '0;
            ptr       <= ID_W'(N - 1);
            grant_id  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state     <= state_next;
            grant     <= grant_next;
            burst_cnt <= burst_next;
            gap_cnt   <= gap_next;
            ptr       <= ptr_next;
            grant_id  <= id_next;
            busy      <= busy_next;
            done      <= done_next;
        end
    end

    enb_retime #(.N(N)) u_retime (
        .clk     (clk),
        .reset_L (reset_L),
        .grant   (grant),
        .enb     (enb)
    );

endmodule

// File: tb/tb_enb_arbiter.sv
// Scoreboard bench for enb_arbiter: expected bursts queued at stimulus, checked at burst end.
module tb_enb_arbiter;

    localparam int N     = 4;
    localparam int BURST = 8;
    localparam int GAP   = 1;

    typedef struct {
        int id;
        int pulses;
        int dones;
    } burst_t;

    logic         clk     = 1'b0;
    logic         reset_L = 1'b0;
    logic [N-1:0] req     = '0;
    logic [N-1:0] enb;
    logic [1:0]   grant_id;
    logic         busy, done;

    logic [N-1:0] req1 = '0;
    logic [N-1:0] enb1;
    logic [1:0]   grant_id1;
    logic         busy1, done1;

    int n_cmp = 0;
    int n_err = 0;
    burst_t exp_q[$];

    enb_arbiter #(.N(N), .BURST(BURST), .GAP(GAP)) dut (
        .clk      (clk),
        .reset_L  (reset_L),
        .req      (req),
        .enb      (enb),
        .grant_id (grant_id),
        .busy     (busy),
        .done     (done)
    );

    enb_arbiter #(.N(N), .BURST(1), .GAP(1)) dut1 (
        .clk      (clk),
        .reset_L  (reset_L),
        .req      (req1),
        .enb      (enb1),
        .grant_id (grant_id1),
        .busy     (busy1),
        .done     (done1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    function automatic int enc(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Waits until the monitor has consumed every queued burst.
    task automatic drain(input int max_cycles);
        int c = 0;
        while (exp_q.size() != 0 && c < max_cycles) begin
            @(posedge clk); #3;
            c++;
        end
        check("drain_timeout", exp_q.size(), 0);
    endtask

    task automatic to_idle();
        repeat (2) @(posedge clk);
        #3;
    endtask

    // Each sample sits 2 time units after a rising edge: enb then shows the
    // value seen by that edge, so a set bit is a gated pulse at that edge.
    initial begin : monitor
        bit     active = 1'b0;
        int     pulses = 0, dones = 0, id_seen = 0, gid_seen = 0;
        burst_t e;
        forever begin
            @(posedge clk); #2;
            check("onehot", 32'($onehot0(enb)), 1);
            if (enb != '0) begin
                if (!active) begin
                    active   = 1'b1;
                    pulses   = 0;
                    dones    = 0;
                    id_seen  = enc(enb);
                    gid_seen = int'(grant_id);
                end
                pulses++;
                if (done) dones++;
            end else if (active) begin
                active = 1'b0;
                if (exp_q.size() == 0) begin
                    check("unexpected_burst", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("burst_enb_id", id_seen, e.id);
                    check("burst_grant_id", gid_seen, e.id);
                    check("burst_pulses", pulses, e.pulses);
                    check("burst_done", dones, e.dones);
                end
                check("busy_after_burst", busy, 0);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin : stimulus
        int exp_ids[5];
        int b1_ids[4];
        int pc[4], pid[4];
        int np = 0, cyc = 0;

        repeat (3) @(posedge clk);
        #3;
        check("rst_enb", enb, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_state", 32'(dut.state), 32'(enb_pkg::IDLE));
        check("rst_ptr", 32'(dut.ptr), N - 1);
        reset_L = 1'b1;

        // Single requester, full burst.
        req = 4'b0100;
        exp_q.push_back('{id: 2, pulses: BURST, dones: 1});
        drain(200);
        req = '0;
        check("single_grant_id", grant_id, 2);
        to_idle();

        // Early release after three pulses, then a fresh full grant.
        req = 4'b0010;
        exp_q.push_back('{id: 1, pulses: 3, dones: 0});
        repeat (3) @(posedge clk);
        #3;
        req = '0;
        drain(50);
        to_idle();
        req = 4'b0010;
        exp_q.push_back('{id: 1, pulses: BURST, dones: 1});
        drain(200);
        req = '0;
        to_idle();

        // Asynchronous reset during pulse 5, while clk is high.
        req = 4'b0100;
        exp_q.push_back('{id: 2, pulses: 5, dones: 0});
        repeat (6) @(posedge clk);
        #3;
        reset_L = 1'b0;
        #1;
        check("async_rst_enb", enb, 0);
        check("async_rst_state", 32'(dut.state), 32'(enb_pkg::IDLE));
        check("async_rst_ptr", 32'(dut.ptr), N - 1);
        check("async_rst_busy", busy, 0);
        req = '0;
        @(posedge clk);
        #3;
        reset_L = 1'b1;
        drain(20);
        to_idle();

        // All requesters held: five back-to-back bursts.
`ifdef ENB_FIXED_PRIORITY_EN
        exp_ids = '{0, 0, 0, 0, 0};
`else
        exp_ids = '{0, 1, 2, 3, 0};
`endif
        req = 4'b1111;
        for (int i = 0; i < 5; i++) exp_q.push_back('{id: exp_ids[i], pulses: BURST, dones: 1});
        drain(300);
        req = '0;
        to_idle();

        // Single-pulse grants on the second instance, two requesters.
`ifdef ENB_FIXED_PRIORITY_EN
        b1_ids = '{0, 0, 0, 0};
`else
        b1_ids = '{0, 1, 0, 1};
`endif
        req1 = 4'b0011;
        while (np < 4 && cyc < 60) begin
            @(posedge clk); #2;
            cyc++;
            if (enb1 != '0) begin
                pc[np]  = cyc;
                pid[np] = enc(enb1);
                check("b1_enb_id", pid[np], b1_ids[np]);
                check("b1_grant_id", grant_id1, b1_ids[np]);
                check("b1_done", done1, 1);
                np++;
            end
        end
        req1 = '0;
        check("b1_pulse_count", np, 4);
        for (int i = 1; i < np; i++) check("b1_spacing", pc[i] - pc[i-1], GAP + 2);
        to_idle();
        check("b1_busy_end", busy1, 0);
        check("final_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
